// File: rtl/alu_pkg.sv
// Shared constants for the alu_sched block: ALU opcodes, scheduler states, stat counter width.
package alu_pkg;

  localparam logic [2:0] ALU_OP_ZERO = 3'd0;
  localparam logic [2:0] ALU_OP_ONE  = 3'd1;
  localparam logic [2:0] ALU_OP_A    = 3'd2;
  localparam logic [2:0] ALU_OP_B    = 3'd3;
  localparam logic [2:0] ALU_OP_ADD  = 3'd4;
  localparam logic [2:0] ALU_OP_SUB  = 3'd5;
  localparam logic [2:0] ALU_OP_AND  = 3'd6;
  localparam logic [2:0] ALU_OP_OR   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  localparam int STAT_W = 8;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; on a tie the one that did not win last wins.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_rr_last,
  output logic [1:0] o_grant
);

  assign o_grant[0] = i_valid[0] & (~i_valid[1] | i_rr_last);
  assign o_grant[1] = i_valid[1] & (~i_valid[0] | ~i_rr_last);

endmodule

// File: rtl/alu_sched.sv
// Two-requester scheduler in front of one shared combinational ALU (IDLE -> ISSUE -> RESP).
// Optional macro ALU_SCHED_STATS_EN adds saturating per-requester completion counters stat0_o/stat1_o.
module alu_sched
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req0_valid_i,
  output logic               req0_ready_o,
  input  logic [2:0]         req0_ctl_i,
  input  logic [2*WIDTH-1:0] req0_ab_i,
  input  logic               req1_valid_i,
  output logic               req1_ready_o,
  input  logic [2:0]         req1_ctl_i,
  input  logic [2*WIDTH-1:0] req1_ab_i,
  output logic               rsp0_valid_o,
  input  logic               rsp0_ready_i,
  output logic [WIDTH-1:0]   rsp0_c_o,
  output logic               rsp1_valid_o,
  input  logic               rsp1_ready_i,
  output logic [WIDTH-1:0]   rsp1_c_o,
  output logic               alu_en_o,
  output logic [2:0]         alu_ctl_o,
  output logic [2*WIDTH-1:0] alu_ab_o,
  input  logic [2*WIDTH-1:0] alu_bc_i
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0]  stat0_o,
  output logic [STAT_W-1:0]  stat1_o
`endif
);

  state_e             r_state;
  state_e             w_next;
  logic               r_rr_last;
  logic               r_owner;
  logic [2:0]         r_alu_ctl;
  logic [2*WIDTH-1:0] r_alu_ab;
  logic [WIDTH-1:0]   r_rsp_c0;
  logic [WIDTH-1:0]   r_rsp_c1;
  logic [1:0]         w_grant;
  logic               w_accept;
  logic               w_rsp_hs;
  logic               w_unused_b;

  rr_arb2 u_arb (
    .i_valid   ({req1_valid_i, req0_valid_i}),
    .i_rr_last (r_rr_last),
    .o_grant   (w_grant)
  );

  assign w_accept   = (r_state == S_IDLE) & (|w_grant);
  assign w_rsp_hs   = (r_state == S_RESP) & (r_owner ? rsp1_ready_i : rsp0_ready_i);
  assign w_unused_b = ^alu_bc_i[2*WIDTH-1:WIDTH];

  assign alu_ctl_o = r_alu_ctl;
  assign alu_ab_o  = r_alu_ab;
  assign rsp0_c_o  = r_rsp_c0;
  assign rsp1_c_o  = r_rsp_c1;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_next       = r_state;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    rsp0_valid_o = 1'b0;
    rsp1_valid_o = 1'b0;
    alu_en_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req0_ready_o = w_grant[0];
        req1_ready_o = w_grant[1];
        if (|w_grant) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        alu_en_o = 1'b1;
        w_next   = S_RESP;
      end
      S_RESP: begin
        rsp0_valid_o = ~r_owner;
        rsp1_valid_o = r_owner;
        if (w_rsp_hs) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_rr_last <= 1'b1;
      r_owner   <= 1'b0;
      r_alu_ctl <= '0;
      r_alu_ab  <= '0;
      r_rsp_c0  <= '0;
      r_rsp_c1  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_owner   <= w_grant[1];
        r_rr_last <= w_grant[1];
        r_alu_ctl <= w_grant[1] ? req1_ctl_i : req0_ctl_i;
        r_alu_ab  <= w_grant[1] ? req1_ab_i  : req0_ab_i;
      end
      // Result lands in the owner's register only; the other side keeps its last value.
      if (r_state == S_ISSUE) begin
        if (r_owner) r_rsp_c1 <= alu_bc_i[WIDTH-1:0];
        else         r_rsp_c0 <= alu_bc_i[WIDTH-1:0];
      end
    end
  end

`ifdef ALU_SCHED_STATS_EN
  logic [STAT_W-1:0] r_stat0;
  logic [STAT_W-1:0] r_stat1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stat0 <= '0;
      r_stat1 <= '0;
    end else begin
      if (rsp0_valid_o & rsp0_ready_i) r_stat0 <= sat_inc(r_stat0);
      if (rsp1_valid_o & rsp1_ready_i) r_stat1 <= sat_inc(r_stat1);
    end
  end

  assign stat0_o = r_stat0;
  assign stat1_o = r_stat1;
`endif

endmodule
